// File: rtl/cdb_pkg.sv
// Shared definitions for the common-data-bus arbiter: default widths, unit indices
// and the result message layout.
package cdb_pkg;

    localparam int TAG_W_DEF  = 3;
    localparam int DATA_W_DEF = 32;
    localparam int MAX_UNITS  = 8;

    localparam int UNIT_ADD = 0;
    localparam int UNIT_MUL = 1;

    typedef struct packed {
        logic [TAG_W_DEF-1:0]  tag;
        logic [DATA_W_DEF-1:0] value;
    } cdb_msg_t;

    // True when two or more holding slots are occupied.
    function automatic logic multi_pending(input logic [MAX_UNITS-1:0] pend);
        logic [3:0] cnt;
        cnt = 4'd0;
        for (int i = 0; i < MAX_UNITS; i++) begin
            cnt = cnt + {3'd0, pend[i]};
        end
        return (cnt >= 4'd2);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority selector: the first set request at or above ptr_i
// (wrapping) wins.
module rr_arbiter #(
    parameter int N     = 2,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     grant_o,
    output logic [IDX_W-1:0] grant_idx_o,
    output logic             any_o
);

    // Scan N positions starting at the pointer and latch onto the first request.
    always_comb begin
        logic found;
        logic hit;
        int   idx;
        found       = 1'b0;
        hit         = 1'b0;
        idx         = 0;
        grant_o     = '0;
        grant_idx_o = '0;
        for (int off = 0; off < N; off++) begin
            idx          = (int'(ptr_i) + off) % N;
            hit          = req_i[idx] & ~found;
            grant_o[idx] = hit;
            grant_idx_o  = hit ? IDX_W'(idx) : grant_idx_o;
            found        = found | hit;
        end
        any_o = found;
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one holding slot per functional unit, round-robin grant,
// one registered broadcast per clock.
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int NUM_UNITS = 2,
    parameter int TAG_W     = TAG_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int SRC_W     = $clog2(NUM_UNITS)
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        flush_i,
    input  logic [NUM_UNITS-1:0]        req_valid_i,
    input  logic [NUM_UNITS*TAG_W-1:0]  req_tag_i,
    input  logic [NUM_UNITS*DATA_W-1:0] req_value_i,
    output logic [NUM_UNITS-1:0]        req_ready_o,
    output logic                        cdb_valid_o,
    output logic [TAG_W-1:0]            cdb_tag_o,
    output logic [DATA_W-1:0]           cdb_value_o,
    output logic [SRC_W-1:0]            cdb_src_o,
    output logic [15:0]                 conflict_cnt_o
);

    logic [NUM_UNITS-1:0]              slot_valid_q, slot_valid_d;
    logic [NUM_UNITS-1:0][TAG_W-1:0]   slot_tag_q, slot_tag_d;
    logic [NUM_UNITS-1:0][DATA_W-1:0]  slot_value_q, slot_value_d;
    logic [SRC_W-1:0]                  rr_ptr_q, rr_ptr_d;
    logic                              cdb_valid_q, cdb_valid_d;
    logic [TAG_W-1:0]                  cdb_tag_q, cdb_tag_d;
    logic [DATA_W-1:0]                 cdb_value_q, cdb_value_d;
    logic [SRC_W-1:0]                  cdb_src_q, cdb_src_d;
    logic [15:0]                       conflict_cnt_q, conflict_cnt_d;

    logic [NUM_UNITS-1:0]              grant_s;
    logic [NUM_UNITS-1:0]              accept_s;
    logic [SRC_W-1:0]                  grant_idx_s;
    logic                              any_s;
    logic [MAX_UNITS-1:0]              pend_pad_s;

    rr_arbiter #(
        .N     (NUM_UNITS),
        .IDX_W (SRC_W)
    ) u_rr (
        .req_i       (slot_valid_q),
        .ptr_i       (rr_ptr_q),
        .grant_o     (grant_s),
        .grant_idx_o (grant_idx_s),
        .any_o       (any_s)
    );

    // A slot being broadcast this cycle is free to take the next result at the same edge.
    assign req_ready_o = {NUM_UNITS{~flush_i}} & (~slot_valid_q | grant_s);
    assign accept_s    = req_valid_i & req_ready_o;

    // Widen the occupancy vector to the fixed width the package helper expects.
    always_comb begin
        pend_pad_s                = '0;
        pend_pad_s[NUM_UNITS-1:0] = slot_valid_q;
    end

    // Holding-slot next state: flush beats refill, refill beats grant-clear.
    always_comb begin
        slot_valid_d = slot_valid_q;
        slot_tag_d   = slot_tag_q;
        slot_value_d = slot_value_q;
        for (int i = 0; i < NUM_UNITS; i++) begin
            if (flush_i) begin
                slot_valid_d[i] = 1'b0;
            end else if (accept_s[i]) begin
                slot_valid_d[i] = 1'b1;
                slot_tag_d[i]   = req_tag_i[i*TAG_W +: TAG_W];
                slot_value_d[i] = req_value_i[i*DATA_W +: DATA_W];
            end else if (grant_s[i]) begin
                slot_valid_d[i] = 1'b0;
            end else begin
                slot_valid_d[i] = slot_valid_q[i];
            end
        end
    end

    // Broadcast, pointer and conflict counter next state; CDB payload holds when idle.
    always_comb begin
        cdb_valid_d    = 1'b0;
        cdb_tag_d      = cdb_tag_q;
        cdb_value_d    = cdb_value_q;
        cdb_src_d      = cdb_src_q;
        rr_ptr_d       = rr_ptr_q;
        conflict_cnt_d = conflict_cnt_q;
        if (flush_i) begin
            cdb_valid_d = 1'b0;
        end else if (any_s) begin
            cdb_valid_d = 1'b1;
            cdb_tag_d   = slot_tag_q[grant_idx_s];
            cdb_value_d = slot_value_q[grant_idx_s];
            cdb_src_d   = grant_idx_s;
            rr_ptr_d    = (grant_idx_s == SRC_W'(NUM_UNITS - 1)) ? '0 : grant_idx_s + SRC_W'(1);
        end else begin
            cdb_valid_d = 1'b0;
        end
        if (!flush_i && multi_pending(pend_pad_s) && (conflict_cnt_q != 16'hFFFF)) begin
            conflict_cnt_d = conflict_cnt_q + 16'd1;
        end else begin
            conflict_cnt_d = conflict_cnt_q;
        end
    end

    // State registers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            slot_valid_q   <= '0;
            slot_tag_q     <= '0;
            slot_value_q   <= '0;
            rr_ptr_q       <= '0;
            cdb_valid_q    <= 1'b0;
            cdb_tag_q      <= '0;
            cdb_value_q    <= '0;
            cdb_src_q      <= '0;
            conflict_cnt_q <= 16'd0;
        end else begin
            slot_valid_q   <= slot_valid_d;
            slot_tag_q     <= slot_tag_d;
            slot_value_q   <= slot_value_d;
            rr_ptr_q       <= rr_ptr_d;
            cdb_valid_q    <= cdb_valid_d;
            cdb_tag_q      <= cdb_tag_d;
            cdb_value_q    <= cdb_value_d;
            cdb_src_q      <= cdb_src_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign cdb_valid_o    = cdb_valid_q;
    assign cdb_tag_o      = cdb_tag_q;
    assign cdb_value_o    = cdb_value_q;
    assign cdb_src_o      = cdb_src_q;
    assign conflict_cnt_o = conflict_cnt_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios with literal expectations plus random
// traffic checked against a slot/queue-level reference model every cycle.
module tb_cdb_arbiter;
    import cdb_pkg::*;

    localparam int N  = 2;
    localparam int TW = 3;
    localparam int DW = 32;
    localparam int SW = 1;

    logic            clk = 1'b0;
    logic            reset;
    logic            flush;
    logic [N-1:0]    req_valid;
    logic [N*TW-1:0] req_tag;
    logic [N*DW-1:0] req_value;
    logic [N-1:0]    req_ready;
    logic            cdb_valid;
    logic [TW-1:0]   cdb_tag;
    logic [DW-1:0]   cdb_value;
    logic [SW-1:0]   cdb_src;
    logic [15:0]     conflict_cnt;

    int checks   = 0;
    int failures = 0;

    // reference model state
    bit          m_valid [N];
    int unsigned m_tag   [N];
    int unsigned m_val   [N];
    int          m_ptr;
    int unsigned m_cnt;
    bit          m_cv;
    int unsigned m_ctag, m_cval, m_csrc;

    cdb_arbiter #(.NUM_UNITS(N), .TAG_W(TW), .DATA_W(DW)) dut (
        .clk_i          (clk),
        .reset_i        (reset),
        .flush_i        (flush),
        .req_valid_i    (req_valid),
        .req_tag_i      (req_tag),
        .req_value_i    (req_value),
        .req_ready_o    (req_ready),
        .cdb_valid_o    (cdb_valid),
        .cdb_tag_o      (cdb_tag),
        .cdb_value_o    (cdb_value),
        .cdb_src_o      (cdb_src),
        .conflict_cnt_o (conflict_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = 0;
            m_val[i]   = 0;
        end
        m_ptr = 0; m_cnt = 0; m_cv = 1'b0; m_ctag = 0; m_cval = 0; m_csrc = 0;
    endtask

    // One clock: drive at the falling edge, check ready, advance model, check registers.
    task automatic cycle(input logic fl, input logic [N-1:0] v,
                         input logic [N*TW-1:0] t, input logic [N*DW-1:0] d);
        int           winner;
        int           pend;
        logic [N-1:0] exp_rdy;
        flush     = fl;
        req_valid = v;
        req_tag   = t;
        req_value = d;
        #1;
        winner = -1;
        pend   = 0;
        for (int k = 0; k < N; k++) begin
            if (winner < 0 && m_valid[(m_ptr + k) % N]) winner = (m_ptr + k) % N;
            pend += m_valid[k] ? 1 : 0;
        end
        for (int i = 0; i < N; i++) exp_rdy[i] = !fl && (!m_valid[i] || winner == i);
        chk("req_ready", req_ready, exp_rdy);
        if (!fl && pend >= 2 && m_cnt < 65535) m_cnt++;
        if (fl) begin
            for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
            m_cv = 1'b0;
        end else begin
            m_cv = (winner >= 0);
            if (winner >= 0) begin
                m_ctag = m_tag[winner];
                m_cval = m_val[winner];
                m_csrc = winner;
                m_valid[winner] = 1'b0;
                m_ptr = (winner + 1) % N;
            end
            for (int i = 0; i < N; i++) begin
                if (v[i] && exp_rdy[i]) begin
                    m_valid[i] = 1'b1;
                    m_tag[i]   = t[i*TW +: TW];
                    m_val[i]   = d[i*DW +: DW];
                end
            end
        end
        @(posedge clk);
        #1;
        chk("cdb_valid", cdb_valid, m_cv);
        chk("cdb_tag", cdb_tag, m_ctag);
        chk("cdb_value", cdb_value, m_cval);
        chk("cdb_src", cdb_src, m_csrc);
        chk("conflict_cnt", conflict_cnt, m_cnt);
        @(negedge clk);
    endtask

    task automatic idle();
        cycle(1'b0, '0, '0, '0);
    endtask

    function automatic logic [N*TW-1:0] tags(input int t0, input int t1);
        logic [N*TW-1:0] r;
        r = '0;
        r[UNIT_ADD*TW +: TW] = TW'(t0);
        r[UNIT_MUL*TW +: TW] = TW'(t1);
        return r;
    endfunction

    function automatic logic [N*DW-1:0] vals(input int unsigned v0, input int unsigned v1);
        logic [N*DW-1:0] r;
        r = '0;
        r[UNIT_ADD*DW +: DW] = v0;
        r[UNIT_MUL*DW +: DW] = v1;
        return r;
    endfunction

    initial begin
        reset = 1'b1; flush = 1'b0; req_valid = '0; req_tag = '0; req_value = '0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_cdb_valid", cdb_valid, 0);
        chk("rst_cdb_tag", cdb_tag, 0);
        chk("rst_cdb_value", cdb_value, 0);
        chk("rst_cdb_src", cdb_src, 0);
        chk("rst_conflict", conflict_cnt, 0);
        reset = 1'b0;
        #1;
        chk("rst_ready", req_ready, 2'b11);

        // collision with pointer at 0
        cycle(1'b0, 2'b11, tags(1, 2), vals(32'h11, 32'h22));
        chk("coll_idle", cdb_valid, 0);
        idle();
        chk("coll_first_tag", cdb_tag, 1);
        chk("coll_first_src", cdb_src, 0);
        chk("coll_cnt", conflict_cnt, 1);
        idle();
        chk("coll_second_tag", cdb_tag, 2);
        chk("coll_second_src", cdb_src, 1);
        chk("coll_cnt_hold", conflict_cnt, 1);

        // single request from the adder
        cycle(1'b0, 2'b01, tags(3, 0), vals(12, 0));
        chk("single_wait", cdb_valid, 0);
        idle();
        chk("single_valid", cdb_valid, 1);
        chk("single_tag", cdb_tag, 3);
        chk("single_value", cdb_value, 12);
        chk("single_src", cdb_src, 0);
        idle();
        chk("single_one_cycle", cdb_valid, 0);
        chk("single_cnt", conflict_cnt, 1);

        // back-to-back refill on the multiplier
        for (int k = 0; k < 4; k++) begin
            if (k < 3) cycle(1'b0, 2'b10, tags(0, 4 + k), vals(0, 40 + k));
            else       idle();
            if (k > 0) begin
                chk("b2b_valid", cdb_valid, 1);
                chk("b2b_tag", cdb_tag, 3 + k);
            end
        end
        idle();
        chk("b2b_done", cdb_valid, 0);

        // flush with both slots full and a new offer
        cycle(1'b0, 2'b11, tags(5, 6), vals(55, 66));
        cycle(1'b1, 2'b11, tags(1, 1), vals(77, 77));
        chk("flush_cdb", cdb_valid, 0);
        idle();
        chk("flush_empty", cdb_valid, 0);
        cycle(1'b0, 2'b01, tags(7, 0), vals(99, 0));
        idle();
        chk("post_flush_tag", cdb_tag, 7);
        chk("post_flush_value", cdb_value, 99);

        // asynchronous reset mid-cycle with slots pending
        cycle(1'b0, 2'b11, tags(2, 3), vals(5, 6));
        idle();
        req_valid = '0;
        #2 reset = 1'b1;
        #1;
        chk("arst_cdb_valid", cdb_valid, 0);
        chk("arst_cdb_tag", cdb_tag, 0);
        chk("arst_cdb_value", cdb_value, 0);
        chk("arst_cdb_src", cdb_src, 0);
        chk("arst_conflict", conflict_cnt, 0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (3) begin
            idle();
            chk("arst_no_bcast", cdb_valid, 0);
        end

        // fairness: both units offer every cycle, pointer starts at 0
        for (int c = 1; c <= 8; c++) begin
            cycle(1'b0, 2'b11, tags(c % 8, (c + 4) % 8), vals(100 + c, 200 + c));
            if (c >= 2) begin
                chk("fair_valid", cdb_valid, 1);
                chk("fair_src", cdb_src, (c - 2) % 2);
            end
        end

        // random traffic
        for (int c = 0; c < 2000; c++) begin
            cycle(($urandom_range(0, 19) == 0), N'($urandom_range(0, 3)),
                  tags($urandom_range(0, 7), $urandom_range(0, 7)),
                  vals($urandom, $urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
